// File: rtl/mig7_traffic_gen.sv
// LFSR-pattern traffic generator for the MIG7 app interface: writes num_beats beats,
// reads them back through a separate checker LFSR and records data mismatches.
module mig7_traffic_gen #(
  parameter int DWIDTH    = 128,
  parameter int AWIDTH    = 28,
  parameter int ADDR_STEP = 8,
  parameter int NBEATS_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [31:0]           seed,
  input  logic [AWIDTH-1:0]     base_addr,
  input  logic [NBEATS_W-1:0]   num_beats,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_cnt,
  output logic [AWIDTH-1:0]     first_err_addr,
  output logic                  err_flag,
  output logic [AWIDTH-1:0]     app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  output logic [DWIDTH-1:0]     app_wdf_data,
  output logic                  app_wdf_end,
  output logic [DWIDTH/8-1:0]   app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_sr_req,
  output logic                  app_ref_req,
  output logic                  app_zq_req,
  input  logic [DWIDTH-1:0]     app_rd_data,
  input  logic                  app_rd_data_end,
  input  logic                  app_rd_data_valid,
  input  logic                  app_rdy,
  input  logic                  app_wdf_rdy,
  input  logic                  app_sr_active,
  input  logic                  app_ref_ack,
  input  logic                  app_zq_ack,
  input  logic                  init_calib_complete
);
  localparam int NW   = DWIDTH / 32;
  localparam int CW   = NBEATS_W + 1;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [AWIDTH-1:0] STEP = AWIDTH'(ADDR_STEP);
  localparam logic [5:0] MAX_OUTS = 6'd32;

  typedef enum logic [2:0] {IDLE, WAIT_CAL, WR, RD, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [1:0]        mode;
    logic [31:0]       seed;
    logic [AWIDTH-1:0] base;
    logic [CW-1:0]     total;
  } cfg_t;

  // Galois form of x^32+x^22+x^2+x+1, shifting toward bit 0
  function automatic logic [31:0] lfsr_nxt(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  state_t            state;
  cfg_t              cfg;
  logic [31:0]       wr_lfsr, chk_lfsr, seed_eff;
  logic [CW-1:0]     cnt, rcv, cnt_inc, rcv_nxt;
  logic [5:0]        outs, outs_nxt;
  logic [AWIDTH-1:0] chk_addr;
  logic [NW-1:0][31:0] wr_pat, chk_pat;
  logic              cmd_acc, cmd_left, dat_left, beat_ok, rd_issue, rd_in, mism;
  logic              unused_ok;

  for (genvar g = 0; g < NW; g++) begin : g_rep
    assign wr_pat[g]  = wr_lfsr;
    assign chk_pat[g] = chk_lfsr;
  end

  assign seed_eff  = (seed == 32'd0) ? 32'd1 : seed;
  assign cmd_acc   = app_en & app_rdy;
  assign cmd_left  = app_en & ~app_rdy;
  assign dat_left  = app_wdf_wren & ~app_wdf_rdy;
  assign beat_ok   = (state == WR) & ~cmd_left & ~dat_left & (app_en | app_wdf_wren);
  assign rd_issue  = cmd_acc & (state == RD);
  assign rd_in     = app_rd_data_valid & ((state == RD) | (state == DRAIN));
  assign mism      = rd_in & (app_rd_data != chk_pat);
  assign cnt_inc   = cnt + CW'(1);
  assign rcv_nxt   = rcv + CW'(rd_in);
  assign outs_nxt  = outs + {5'd0, rd_issue} - {5'd0, rd_in};

  assign busy         = (state == WAIT_CAL) | (state == WR) | (state == RD) | (state == DRAIN);
  assign app_wdf_data = wr_pat;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;
  assign app_sr_req   = 1'b0;
  assign app_ref_req  = 1'b0;
  assign app_zq_req   = 1'b0;
  assign unused_ok    = &{1'b0, app_rd_data_end, app_sr_active, app_ref_ack, app_zq_ack};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cfg            <= '0;
      wr_lfsr        <= '0;
      chk_lfsr       <= '0;
      cnt            <= '0;
      rcv            <= '0;
      outs           <= '0;
      chk_addr       <= '0;
      app_addr       <= '0;
      app_cmd        <= 3'b000;
      app_en         <= 1'b0;
      app_wdf_wren   <= 1'b0;
      done           <= 1'b0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
    end else begin
      if (rd_in) begin
        chk_lfsr <= lfsr_nxt(chk_lfsr);
        rcv      <= rcv_nxt;
        chk_addr <= chk_addr + STEP;
        if (mism) begin
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          if (!err_flag) begin
            err_flag       <= 1'b1;
            first_err_addr <= chk_addr;
          end
        end
      end
      outs <= outs_nxt;

      case (state)
        IDLE, DONE: begin
          if (start && mode != 2'd3) begin
            state          <= WAIT_CAL;
            done           <= 1'b0;
            cfg            <= '{mode: mode, seed: seed_eff, base: base_addr,
                                total: {(num_beats == '0), num_beats}};
            wr_lfsr        <= seed_eff;
            chk_lfsr       <= seed_eff;
            app_addr       <= base_addr;
            chk_addr       <= base_addr;
            cnt            <= '0;
            rcv            <= '0;
            outs           <= '0;
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
          end
        end
        WAIT_CAL: begin
          if (init_calib_complete) begin
            app_en <= 1'b1;
            if (cfg.mode == 2'd1) begin
              state   <= RD;
              app_cmd <= 3'b001;
            end else begin
              state        <= WR;
              app_cmd      <= 3'b000;
              app_wdf_wren <= 1'b1;
            end
          end
        end
        WR: begin
          if (beat_ok) begin
            if (cnt_inc == cfg.total) begin
              cnt          <= '0;
              app_en       <= 1'b0;
              app_wdf_wren <= 1'b0;
              if (cfg.mode == 2'd2) begin
                // read-back pass restarts from the latched base and seed
                state    <= RD;
                app_cmd  <= 3'b001;
                app_addr <= cfg.base;
                wr_lfsr  <= cfg.seed;
                app_en   <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              cnt          <= cnt_inc;
              app_addr     <= app_addr + STEP;
              wr_lfsr      <= lfsr_nxt(wr_lfsr);
              app_en       <= 1'b1;
              app_wdf_wren <= 1'b1;
            end
          end else begin
            app_en       <= cmd_left;
            app_wdf_wren <= dat_left;
          end
        end
        RD: begin
          if (cmd_acc) begin
            cnt      <= cnt_inc;
            app_addr <= app_addr + STEP;
          end
          if (cmd_acc && cnt_inc == cfg.total) begin
            state  <= DRAIN;
            app_en <= 1'b0;
          end else begin
            // stall issue while 32 reads are in flight
            app_en <= (outs_nxt < MAX_OUTS);
          end
        end
        DRAIN: begin
          if (rcv_nxt == cfg.total) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mig7_traffic_gen.sv
// Randomized bench for mig7_traffic_gen: a memory responder with random ready and
// read latency, checked against address/pattern lists built from the LFSR rule.
`timescale 1ns/1ps
module tb_mig7_traffic_gen;
  localparam int DW = 128, AW = 28, STEP = 8, NBW = 16;
  localparam int NW = DW / 32;

  logic              clk = 1'b0;
  logic              rst, start, init_calib_complete;
  logic [1:0]        mode;
  logic [31:0]       seed;
  logic [AW-1:0]     base_addr;
  logic [NBW-1:0]    num_beats;
  logic              busy, done, err_flag;
  logic [15:0]       err_cnt;
  logic [AW-1:0]     first_err_addr, app_addr;
  logic [2:0]        app_cmd;
  logic              app_en, app_wdf_end, app_wdf_wren, app_sr_req, app_ref_req, app_zq_req;
  logic [DW-1:0]     app_wdf_data, app_rd_data;
  logic [DW/8-1:0]   app_wdf_mask;
  logic              app_rd_data_valid, app_rdy, app_wdf_rdy;

  always #5 clk = ~clk;

  mig7_traffic_gen #(.DWIDTH(DW), .AWIDTH(AW), .ADDR_STEP(STEP), .NBEATS_W(NBW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .base_addr(base_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .err_flag(err_flag), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_sr_req(app_sr_req), .app_ref_req(app_ref_req),
    .app_zq_req(app_zq_req), .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_valid),
    .app_rd_data_valid(app_rd_data_valid), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_sr_active(1'b0), .app_ref_ack(1'b0), .app_zq_ack(1'b0),
    .init_calib_complete(init_calib_complete)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [DW-1:0] rep(input logic [31:0] w);
    return {NW{w}};
  endfunction

  // ---------------- memory responder ----------------
  typedef struct { logic [2:0] cmd; logic [AW-1:0] addr; } cmd_t;
  typedef struct { int due; logic [DW-1:0] data; } rd_t;

  cmd_t          cmd_log[$];
  logic [DW-1:0] dat_log[$];
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  rd_t           rd_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  bit            corrupt [int];
  int            cyc, lat, rd_idx, ret_cnt, outs, outs_max, en_nocal;
  bit            rnd_rdy;

  initial begin
    logic hs_c, hs_d;
    logic [DW-1:0] d;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
    cyc = 0; lat = 4; rd_idx = 0; ret_cnt = 0; outs = 0; outs_max = 0; en_nocal = 0; rnd_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        app_rd_data_valid = 1'b0;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        outs = 0;
        continue;
      end
      app_rdy     = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      app_wdf_rdy = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (app_en && !init_calib_complete) en_nocal++;
      hs_c = app_en && app_rdy;
      hs_d = app_wdf_wren && app_wdf_rdy;
      if (hs_d) begin
        dat_log.push_back(app_wdf_data);
        wd_q.push_back(app_wdf_data);
      end
      if (hs_c) begin
        cmd_log.push_back('{app_cmd, app_addr});
        if (app_cmd == 3'b000) wa_q.push_back(app_addr);
      end
      while (wa_q.size() > 0 && wd_q.size() > 0) mem[wa_q.pop_front()] = wd_q.pop_front();
      if (hs_c && app_cmd == 3'b001) begin
        d = mem.exists(app_addr) ? mem[app_addr] : '0;
        if (corrupt.exists(rd_idx)) d[0] = ~d[0];
        rd_q.push_back('{cyc + lat, d});
        rd_idx++;
      end
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = rd_q[0].data;
        void'(rd_q.pop_front());
        ret_cnt++;
      end else begin
        app_rd_data_valid = 1'b0;
        app_rd_data = {NW{$urandom}};
      end
      outs = outs + int'(hs_c && app_cmd == 3'b001) - int'(app_rd_data_valid);
      if (outs > outs_max) outs_max = outs;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  // One complete run; caller may pre-load corrupt[] with read-beat indices to flip.
  task automatic run(input string tag, input logic [1:0] m, input logic [31:0] sd,
                     input logic [AW-1:0] ba, input int n, input int lt, input bit rr,
                     input int cal_dly, input bit poke);
    logic [31:0]   pat[$];
    logic [AW-1:0] ad[$];
    logic [31:0]   s;
    int            to, ret_at_done, n_cmd, first_k;
    s = (sd == 32'd0) ? 32'd1 : sd;
    for (int i = 0; i < n; i++) begin
      pat.push_back(s);
      s = lfsr_step(s);
      ad.push_back(AW'((longint'(ba) + longint'(i) * STEP) % (longint'(1) << AW)));
    end
    mem.delete(); cmd_log.delete(); dat_log.delete();
    rd_idx = 0; ret_cnt = 0; outs_max = 0; en_nocal = 0; lat = lt; rnd_rdy = rr;
    if (m == 2'd1) for (int i = 0; i < n; i++) mem[ad[i]] = rep(pat[i]);
    if (cal_dly > 0) init_calib_complete = 1'b0;
    mode = m; seed = sd; base_addr = ba; num_beats = NBW'(n); start = 1'b1;
    step();
    start = 1'b0;
    if (cal_dly > 0) begin
      repeat (cal_dly) step();
      chk({tag, "_cal_busy"}, busy, 1'b1);
      chk({tag, "_cal_en"}, en_nocal, 0);
      init_calib_complete = 1'b1;
    end
    if (poke) begin
      repeat (3) step();
      mode = 2'd0; base_addr = AW'('h100); num_beats = NBW'(1); start = 1'b1;
      step();
      start = 1'b0;
    end
    to = 0;
    while (!done && to < 20000) begin step(); to++; end
    ret_at_done = ret_cnt;
    chk({tag, "_timeout"}, (to < 20000), 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);

    n_cmd = (m == 2'd2) ? 2 * n : n;
    chk({tag, "_ncmd"}, cmd_log.size(), n_cmd);
    for (int i = 0; i < n_cmd && i < cmd_log.size(); i++) begin
      logic [2:0] ec;
      ec = (m == 2'd1 || i >= n) ? 3'b001 : 3'b000;
      chk($sformatf("%s_cmd%0d", tag, i), {cmd_log[i].cmd, cmd_log[i].addr}, {ec, ad[i % n]});
    end
    chk({tag, "_ndat"}, dat_log.size(), (m == 2'd1) ? 0 : n);
    for (int i = 0; i < n && i < dat_log.size(); i++)
      chk($sformatf("%s_dat%0d", tag, i), dat_log[i], rep(pat[i]));
    chk({tag, "_ret"}, ret_at_done, (m == 2'd0) ? 0 : n);
    if (m != 2'd0) chk({tag, "_outs_le32"}, (outs_max <= 32), 1'b1);

    first_k = 0;
    if (corrupt.num() > 0) void'(corrupt.first(first_k));
    chk({tag, "_err_cnt"}, err_cnt, corrupt.num());
    chk({tag, "_err_flag"}, err_flag, (corrupt.num() > 0));
    chk({tag, "_fea"}, first_err_addr, (corrupt.num() > 0) ? ad[first_k] : '0);
  endtask

  initial begin
    logic [AW-1:0] b;
    int n, k, to;
    logic [1:0] m;
    rst = 1'b1; start = 1'b0; mode = '0; seed = '0; base_addr = '0; num_beats = '0;
    init_calib_complete = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_en", app_en, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_err", {err_flag, err_cnt, first_err_addr}, '0);
    chk("rst_addr_cmd", {app_addr, app_cmd}, '0);
    chk("ties", {app_sr_req, app_ref_req, app_zq_req, app_wdf_mask}, '0);

    // mode 3 is not a run
    mode = 2'd3; start = 1'b1; step(); start = 1'b0; step();
    chk("mode3_busy", busy, 1'b0);
    chk("mode3_en", app_en, 1'b0);

    run("ideal", 2'd2, 32'h1234_5678, '0, 16, 5, 1'b0, 0, 1'b0);
    chk("ideal_done", done, 1'b1);
    chk("ideal_last_wr_addr", cmd_log[15].addr, AW'(120));

    corrupt[5] = 1'b1;
    run("bit0", 2'd2, 32'h1234_5678, '0, 16, 5, 1'b0, 0, 1'b0);
    chk("bit0_fea40", first_err_addr, AW'(40));
    chk("bit0_cnt1", err_cnt, 16'd1);
    corrupt.delete();

    b = AW'($urandom); b[2:0] = '0;
    run("rndrdy", 2'd0, $urandom, b, 20, 3, 1'b1, 0, 1'b0);

    run("lat100", 2'd1, $urandom, '0, 64, 100, 1'b0, 0, 1'b0);
    chk("lat100_outs_max", outs_max, 32);

    run("wrap", 2'd1, $urandom, AW'(28'hFFF_FFF0), 4, 4, 1'b1, 0, 1'b0);
    chk("wrap_a2", cmd_log[2].addr, AW'(0));
    chk("wrap_a3", cmd_log[3].addr, AW'(8));

    run("cal", 2'd2, 32'd0, AW'('h40), 8, 6, 1'b1, 50, 1'b0);
    run("poke", 2'd2, $urandom, AW'('h800), 12, 7, 1'b1, 0, 1'b1);

    // reset in the middle of a read run
    b = '0;
    for (int i = 0; i < 200; i++) mem[AW'(i * STEP)] = '0;
    lat = 20; rnd_rdy = 1'b0; cmd_log.delete(); ret_cnt = 0;
    mode = 2'd1; seed = 32'h0bad_cafe; base_addr = b; num_beats = NBW'(200); start = 1'b1;
    step();
    start = 1'b0;
    to = 0;
    while (ret_cnt < 5 && to < 1000) begin step(); to++; end
    chk("midrd_reached", (to < 1000), 1'b1);
    chk("midrd_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrd_busy", busy, 1'b0);
    chk("midrd_done", done, 1'b0);
    chk("midrd_en", {app_en, app_wdf_wren}, '0);
    chk("midrd_err", {err_flag, err_cnt, first_err_addr}, '0);
    chk("midrd_addr_cmd", {app_addr, app_cmd}, '0);
    step();

    for (int r = 0; r < 6; r++) begin
      m = 2'($urandom_range(0, 2));
      n = $urandom_range(1, 40);
      b = AW'($urandom); b[2:0] = '0;
      corrupt.delete();
      if (m != 2'd0) begin
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) corrupt[$urandom_range(0, n - 1)] = 1'b1;
      end
      run($sformatf("rnd%0d", r), m, $urandom, b, n, $urandom_range(1, 40),
          1'($urandom_range(0, 1)), 0, 1'b0);
    end
    corrupt.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mig7_traffic_gen.md
MIG7_TRAFFIC_GEN -- requirements
Module: mig7_traffic_gen

Interface
REQ-001 SHALL have parameter DWIDTH, default 128, app data width (multiple of 32).
REQ-002 SHALL have parameter AWIDTH, default 28, app address width.
REQ-003 SHALL have parameter ADDR_STEP, default 8, address increment per beat.
REQ-004 SHALL have parameter NBEATS_W, default 16, width of beat-count input.
REQ-005 SHALL use one clock and synchronous active-high reset; ports: clk in 1, MIG ui clock; rst in 1, reset.
REQ-006 SHALL have start in 1 (pulse, launches a run), mode in 2 (0 write, 1 read-check, 2 write-then-read, 3 reserved).
REQ-007 SHALL have seed in 32, base_addr in AWIDTH, num_beats in NBEATS_W (0 means 2^NBEATS_W).
REQ-008 SHALL have busy out 1, done out 1, err_cnt out 16, first_err_addr out AWIDTH, err_flag out 1.
REQ-009 SHALL drive app_addr AWIDTH, app_cmd 3, app_en 1, app_wdf_data DWIDTH, app_wdf_end 1, app_wdf_mask DWIDTH/8, app_wdf_wren 1, app_sr_req 1, app_ref_req 1, app_zq_req 1.
REQ-010 SHALL receive app_rd_data DWIDTH, app_rd_data_end 1, app_rd_data_valid 1, app_rdy 1, app_wdf_rdy 1, app_sr_active 1, app_ref_ack 1, app_zq_ack 1, init_calib_complete 1.

Function
REQ-011 SHALL tie app_sr_req, app_ref_req, app_zq_req and app_wdf_mask to 0.
REQ-012 SHALL implement states IDLE, WAIT_CAL, WR, RD, DRAIN, DONE.
REQ-013 IDLE/DONE: start with mode!=3 -> WAIT_CAL, latching mode, seed, base_addr, num_beats; start with mode 3 ignored; start while busy ignored.
REQ-014 WAIT_CAL -> WR (mode 0/2) or RD (mode 1) on first cycle init_calib_complete=1.
REQ-015 Pattern: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, loaded with seed (seed 0 replaced by 32'h1); beat data = LFSR value replicated DWIDTH/32 times; LFSR advances once per accepted beat.
REQ-016 WR: app_cmd=3'b000, app_wdf_end=app_wdf_wren; app_en and app_wdf_wren held until their own handshake (app_en&app_rdy, app_wdf_wren&app_wdf_rdy); command and data accepted independently; beat complete when both accepted; address += ADDR_STEP per beat, wraps modulo 2^AWIDTH.
REQ-017 WR end: after num_beats complete -> RD (mode 2, address and LFSR reloaded from latched base/seed) or DONE (mode 0).
REQ-018 RD: app_cmd=3'b001; issues num_beats read commands, address stepping as REQ-016; outstanding-read counter never exceeds 32, app_en deasserted while at 32.
REQ-019 Check: each app_rd_data_valid compared to checker LFSR pattern (separate LFSR, same seed); mismatch increments err_cnt, saturating at 16'hFFFF.
REQ-020 first_err_addr SHALL capture the address of the first mismatching beat of the run; err_flag SHALL set with it and hold until next start.
REQ-021 RD -> DRAIN after last command accepted; DRAIN -> DONE when received-beat count equals num_beats.
REQ-022 Simultaneous command issue and data return in one cycle SHALL leave outstanding counter unchanged.
REQ-023 busy=1 in WAIT_CAL, WR, RD, DRAIN; done=1 in DONE only, held until next accepted start.
REQ-024 err_cnt, first_err_addr, err_flag SHALL clear on accepted start.
REQ-025 app_rd_data_valid outside RD/DRAIN SHALL be ignored.

Reset
REQ-026 rst SHALL force IDLE next cycle from any state, including mid-handshake; app_en, app_wdf_wren, busy, done, err_flag =0; err_cnt=0; first_err_addr=0; app_addr=0; app_cmd=0; counters and LFSRs cleared.

Verification
REQ-027 mode 2, seed 32'h1234_5678, base 0, num_beats 16, ideal memory model -> 16 writes at addr 0..120 step 8, 16 reads, err_cnt=0, done=1.
REQ-028 Same run, model corrupts bit 0 of beat 5 -> err_cnt=1, first_err_addr=40, err_flag=1.
REQ-029 mode 0, app_rdy and app_wdf_rdy toggled independently at random -> exactly num_beats of each handshake, data order matches LFSR sequence.
REQ-030 mode 1, read latency 100 cycles, num_beats 64 -> outstanding never >32, DONE after 64th return.
REQ-031 init_calib_complete low 50 cycles after start -> no app_en until calibration high; rst asserted mid-RD -> IDLE next cycle, all outputs at reset values.
REQ-032 mode 1, base_addr 2^28-16, num_beats 4 -> addresses 2^28-16, 2^28-8, 0, 8.
